// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter sharing one 8:1 single-bit mux among 8 requesters.
// It registers a one-hot grant and the matching 3-bit mux select, so the bit
// that requester i drives on the mux option bus reaches the mux output while i
// owns the grant. A hold quantum bounds how long one owner keeps the mux while
// other requesters are waiting.
//
// Parameters:
//   QUANTUM      maximum consecutive cycles one owner holds the grant while
//                others wait (1..255)
//   CW           owner_cycles width, derived from QUANTUM
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req[7:0]     request vector; req[i] held high while requester i wants the mux
//   grant[7:0]   registered one-hot grant; all-zero when idle
//   sel[2:0]     registered mux select; index of the grant bit while valid,
//                last owner while idle
//   valid        high when some grant bit is set
//   owner_cycles cycles the current owner has held the grant (1 on the first
//                cycle); 0 when idle
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int unsigned  QUANTUM = 8,
  localparam int unsigned CW      = $clog2(QUANTUM + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    req,
  output logic [7:0]    grant,
  output logic [2:0]    sel,
  output logic          valid,
  output logic [CW-1:0] owner_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    grant_q, grant_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    ptr_q, ptr_d;          // highest-priority index for the next pick
  logic [CW-1:0] owner_cycles_q, owner_cycles_d;

  // First set bit of mask, scanning base, base+1, ... and wrapping mod 8.
  // Only meaningful when mask is non-zero; callers guard on that.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask,
                                         input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = base + 3'(k);
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration helpers
  // ---------------------------------------------------------------------------
  logic [7:0]    owner_oh;
  logic [7:0]    others;                // requests excluding the current owner
  logic          owner_req;
  logic          quantum_hit;
  logic [2:0]    pick_all;
  logic [2:0]    pick_others;
  logic [CW-1:0] cycles_inc;

  assign owner_oh    = 8'b1 << sel_q;
  assign others      = req & ~owner_oh;
  assign owner_req   = req[sel_q];
  assign quantum_hit = (owner_cycles_q == CW'(QUANTUM));
  assign pick_all    = rr_pick(req, ptr_q);
  assign pick_others = rr_pick(others, ptr_q);
  assign cycles_inc  = owner_cycles_q + CW'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       do_grant;
  logic [2:0] winner;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    grant_d        = grant_q;
    sel_d          = sel_q;
    ptr_d          = ptr_q;
    owner_cycles_d = owner_cycles_q;
    do_grant       = 1'b0;
    winner         = pick_all;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          winner   = pick_all;
        end
      end

      BUSY: begin
        if (owner_req && !quantum_hit) begin
          owner_cycles_d = cycles_inc;
        end else if (|others) begin
          // Owner released or used up its quantum while others wait: hand off
          // on this edge, so there is never an idle bubble between owners.
          do_grant = 1'b1;
          winner   = pick_others;
        end else if (owner_req) begin
          // Quantum expired but nobody else wants the mux: renew in place.
          owner_cycles_d = CW'(1);
        end else begin
          // Released with no other requester. sel keeps the last owner so the
          // mux input does not move while idle.
          grant_d        = '0;
          owner_cycles_d = '0;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      grant_d        = 8'b1 << winner;
      sel_d          = winner;
      owner_cycles_d = CW'(1);
      ptr_d          = winner + 3'd1;   // wraps 7 -> 0 naturally
      state_d        = BUSY;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: every control flop takes the async reset so the mux select and grant
  // are known the instant rst rises, not one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      sel_q          <= '0;
      ptr_q          <= '0;
      owner_cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      grant_q        <= grant_d;
      sel_q          <= sel_d;
      ptr_q          <= ptr_d;
      owner_cycles_q <= owner_cycles_d;
    end
  end

  assign grant        = grant_q;
  assign sel          = sel_q;
  assign valid        = |grant_q;
  assign owner_cycles = owner_cycles_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));

  a_sel_matches_grant: assert property (@(posedge clk) disable iff (rst)
    grant_q[sel_q] == valid);

  a_cycles_capped: assert property (@(posedge clk) disable iff (rst)
    owner_cycles_q <= CW'(QUANTUM));

  a_idle_cycles_zero: assert property (@(posedge clk) disable iff (rst)
    !valid |-> (owner_cycles_q == '0));

  a_state_matches_valid: assert property (@(posedge clk) disable iff (rst)
    (state_q == BUSY) == valid);

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 single-bit mux (select input [2:0], option bus [7:0]) among 8 requesters.
- Registers a one-hot grant plus the matching 3-bit select, so requester i's bit on the mux option bus reaches the mux output while i owns the grant.
- Enforces a hold quantum so no requester starves the others.
- Sits between the requester agents and the mux select pin.

Parameters:
- QUANTUM, 8, maximum consecutive cycles one owner holds the grant while others wait. Legal range 1..255.
- CW, $clog2(QUANTUM+1), quantum counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; requester i holds req[i]=1 while it wants the mux
- grant  output  8  one-hot grant, registered; all-zero when idle
- sel  output  3  mux select, registered; equals index of grant bit while valid
- valid  output  1  1 when some grant bit is set
- owner_cycles  output  CW  cycles the current owner has held the grant (1 on first cycle); 0 when idle

Behaviour:
- Reset (async, any cycle, including mid-grant): grant=0, sel=0, valid=0, owner_cycles=0, ptr=0, state=IDLE. All outputs change immediately on rst assertion.
- State: IDLE, BUSY. ptr[2:0] is the highest-priority index for the next arbitration.
- Arbitration function pick(mask): first set bit of mask scanning ptr, ptr+1, ..., ptr+7, wrapping mod 8.
- IDLE:
  - If req!=0: next edge grant=onehot(w), sel=w, valid=1, owner_cycles=1, ptr=w+1 mod 8, go BUSY, where w=pick(req).
  - Latency from req rising to grant: exactly 1 cycle.
- BUSY, owner o=sel:
  - Release: if req[o]=0, next edge ends o's grant. Let m = req with bit o cleared.
    - If m!=0: grant w=pick(m) on the same edge; sel=w, owner_cycles=1, ptr=w+1; stay BUSY. No bubble cycle.
    - If m==0: grant=0, valid=0, owner_cycles=0, go IDLE. sel holds o.
  - Preempt: if req[o]=1 and owner_cycles==QUANTUM and m!=0, hand off to w=pick(m) exactly as above. o must re-request to be served again in round-robin order.
  - Renew: if req[o]=1, owner_cycles==QUANTUM and m==0, o keeps the grant; owner_cycles=1.
  - Otherwise o keeps the grant; owner_cycles increments.
- Simultaneous release by the owner and new requests: the new requests are arbitrated on that same edge.
- ptr wrap: after granting 7, ptr=0.
- sel is stable while valid=1 (the mux output is glitch-free per owner). When idle, sel retains the last owner.
- Invariants:
  - grant is one-hot or zero.
  - valid == |grant.
  - grant[sel]==valid.
  - owner_cycles never exceeds QUANTUM.
- QUANTUM=1 degenerates to per-cycle round-robin among active requesters.

Test Plan:
- Reset then req=8'b0000_0100 → next cycle grant=0000_0100, sel=2, valid=1, owner_cycles=1. Drop req → next cycle grant=0, valid=0, sel stays 2.
- req=8'hFF held constant, QUANTUM=2 → owners 0,0,1,1,2,2,...,7,7,0 in order, sel tracking, never idle.
- Owner 3 holds; req[5] and req[1] asserted; owner drops req[3] → same edge grant=0010_0000 (ptr=4 favours 5 over 1), owner_cycles=1, no valid=0 cycle.
- Single requester 6 held 3*QUANTUM cycles → grant stays 0100_0000; owner_cycles counts 1..QUANTUM and renews to 1 each quantum.
- Assert rst mid-grant (owner 4, owner_cycles=3) → grant=0, sel=0, valid=0 immediately. After release with req=8'h90: grant goes to 4 (ptr=0 scan finds 4 before 7).
- Random req for 10k cycles, QUANTUM=4, with a scoreboard:
  - Invariants hold every cycle.
  - No requester with req held continuously waits more than 7*QUANTUM cycles.
